// File: rtl/wramp_bus_responder.sv
// rtl/wramp_bus_responder.sv - WRAMP bus slave: RAM, switches, SSD register and countdown timer
module wramp_bus_responder #(
   parameter int    RAM_DEPTH = 16384,
   parameter string INIT_FILE = "",
   parameter int    TICK_DIV  = 50000,
   parameter int    SW_WIDTH  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [19:0]         mem_address,
   input  logic                mem_write_enable,
   input  logic [31:0]         mem_write_value,
   output logic [31:0]         mem_read_value,
   input  logic [SW_WIDTH-1:0] switches,
   output logic [31:0]         ssd_value,
   output logic                timer_irq
);
   localparam int          AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [19:0] A_SW      = 20'h70000;
   localparam logic [19:0] A_SSD     = 20'h70001;
   localparam logic [19:0] A_CTRL    = 20'h71000;
   localparam logic [19:0] A_LOAD    = 20'h71001;
   localparam logic [19:0] A_COUNT   = 20'h71002;
   localparam logic [19:0] A_STAT    = 20'h71003;
   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

   logic [31:0]         ram [RAM_DEPTH];
   logic                we_q;
   logic [19:0]         addr_q;
   logic                commit;
   logic                ram_hit;
   logic                wr_ssd, wr_ctrl, wr_load, wr_stat;
   logic [31:0]         ram_q;
   logic [31:0]         reg_q;
   logic [31:0]         reg_rd;
   logic                sel_ram_q;
   logic [SW_WIDTH-1:0] sw_meta, sw_sync;
   logic [1:0]          ctrl, status;
   logic [31:0]         load, count, prescaler;
   logic                tick, expire;

   assign ram_hit = ({12'd0, mem_address} < 32'(RAM_DEPTH));

   // The CPU holds write enable across several cycles; only the first cycle of a hold commits.
   assign commit  = mem_write_enable && !rst && (!we_q || (mem_address != addr_q));
   assign wr_ssd  = commit && (mem_address == A_SSD);
   assign wr_ctrl = commit && (mem_address == A_CTRL);
   assign wr_load = commit && (mem_address == A_LOAD);
   assign wr_stat = commit && (mem_address == A_STAT);

   assign tick      = ctrl[0] && (prescaler == TICK_LAST);
   assign expire    = tick && (count == 32'd0);
   assign timer_irq = status[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         addr_q <= 20'd0;
      end else begin
         we_q   <= mem_write_enable;
         addr_q <= mem_address;
      end
   end

   always_ff @(posedge clk) begin
      if (commit && ram_hit) begin
         ram[mem_address[AW-1:0]] <= mem_write_value;
      end
      ram_q <= ram[mem_address[AW-1:0]];
   end

   always_comb begin
      reg_rd = 32'd0;
      case (mem_address)
         A_SW:    reg_rd = 32'(sw_sync);
         A_SSD:   reg_rd = ssd_value;
         A_CTRL:  reg_rd = {30'd0, ctrl};
         A_LOAD:  reg_rd = load;
         A_COUNT: reg_rd = count;
         A_STAT:  reg_rd = {30'd0, status};
         default: reg_rd = 32'd0;
      endcase
   end

   // RAM output is selected after the edge so the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_q     <= 32'd0;
         sel_ram_q <= 1'b0;
      end else begin
         reg_q     <= reg_rd;
         sel_ram_q <= ram_hit;
      end
   end

   assign mem_read_value = sel_ram_q ? ram_q : reg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta   <= '0;
         sw_sync   <= '0;
         ssd_value <= 32'd0;
      end else begin
         sw_meta <= switches;
         sw_sync <= sw_meta;
         if (wr_ssd) begin
            ssd_value <= mem_write_value;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler <= 32'd0;
         count     <= 32'd0;
         load      <= 32'd0;
         ctrl      <= 2'd0;
         status    <= 2'd0;
      end else begin
         if (wr_load || (wr_ctrl && mem_write_value[0]) || !ctrl[0] || tick) begin
            prescaler <= 32'd0;
         end else begin
            prescaler <= prescaler + 32'd1;
         end

         if (wr_load) begin
            load  <= mem_write_value;
            count <= mem_write_value;
         end else if (tick && (count != 32'd0)) begin
            count <= count - 32'd1;
         end else if (expire && ctrl[1]) begin
            count <= load;
         end

         if (wr_ctrl) begin
            ctrl <= mem_write_value[1:0];
         end else if (expire && !ctrl[1]) begin
            ctrl[0] <= 1'b0;
         end

         // An expiry outranks a simultaneous status write so no event is lost.
         if (expire) begin
            status <= {status[0], 1'b1};
         end else if (wr_stat) begin
            status <= mem_write_value[1:0];
         end
      end
   end
endmodule

// File: tb/tb_wramp_bus_responder.sv
// tb/tb_wramp_bus_responder.sv - scoreboard bench for wramp_bus_responder
module tb_wramp_bus_responder;
   localparam int K_NONE = 0;
   localparam int K_RD   = 1;
   localparam int K_SSD  = 2;
   localparam int K_IRQ  = 3;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } chk_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] mem_address;
   logic        mem_write_enable;
   logic [31:0] mem_write_value;
   logic [31:0] mem_read_value;
   logic [15:0] switches;
   logic [31:0] ssd_value;
   logic        timer_irq;

   chk_t        sb[$];
   chk_t        me;
   logic [31:0] act;
   int          n_vec  = 0;
   int          n_fail = 0;

   wramp_bus_responder #(
      .RAM_DEPTH(16384),
      .INIT_FILE(""),
      .TICK_DIV (4),
      .SW_WIDTH (16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_address      (mem_address),
      .mem_write_enable (mem_write_enable),
      .mem_write_value  (mem_write_value),
      .mem_read_value   (mem_read_value),
      .switches         (switches),
      .ssd_value        (ssd_value),
      .timer_irq        (timer_irq)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic r, input logic [19:0] a, input logic w,
                      input logic [31:0] d, input int kind, input logic [31:0] exp,
                      input string name);
      chk_t e;
      rst              = r;
      mem_address      = a;
      mem_write_enable = w;
      mem_write_value  = d;
      e.kind = kind;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            me = sb.pop_front();
            case (me.kind)
               K_RD:    act = mem_read_value;
               K_SSD:   act = ssd_value;
               K_IRQ:   act = {31'd0, timer_irq};
               default: act = 32'd0;
            endcase
            if (me.kind != K_NONE) begin
               n_vec++;
               if (act !== me.exp) begin
                  n_fail++;
                  $display("FAIL %s: got %08h expected %08h", me.name, act, me.exp);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        r, w;
      logic [19:0] a;
      logic [31:0] d, ex;
      int          kd;

      rst = 1'b1;
      mem_address = 20'd0;
      mem_write_enable = 1'b0;
      mem_write_value = 32'd0;
      switches = 16'd0;
      @(negedge clk);

      cyc(1'b1, 20'($urandom), 1'($urandom_range(0, 1)), $urandom, K_RD, 32'd0, "rst_rdata");
      cyc(1'b1, 20'($urandom), 1'($urandom_range(0, 1)), $urandom, K_SSD, 32'd0, "rst_ssd");
      cyc(1'b0, 20'h40000, 1'b0, 32'd0, K_IRQ, 32'd0, "rst_irq");

      cyc(1'b0, 20'h00010, 1'b1, 32'h11111111, K_NONE, 32'd0, "ram_seed");
      cyc(1'b0, 20'h40000, 1'b0, 32'd0, K_RD, 32'd0, "unmapped_rd");
      cyc(1'b0, 20'h00010, 1'b1, 32'hDEADBEEF, K_RD, 32'h11111111, "ram_read_first");
      cyc(1'b0, 20'h00010, 1'b1, 32'hBAD0BAD0, K_RD, 32'hDEADBEEF, "ram_hold1");
      cyc(1'b0, 20'h00010, 1'b1, 32'hBAD1BAD1, K_RD, 32'hDEADBEEF, "ram_hold2");
      cyc(1'b0, 20'h00010, 1'b0, 32'd0, K_RD, 32'hDEADBEEF, "ram_rd");

      cyc(1'b0, 20'h70001, 1'b1, 32'h00001234, K_SSD, 32'h00001234, "ssd_commit");
      cyc(1'b0, 20'h70001, 1'b0, 32'd0, K_RD, 32'h00001234, "ssd_rd");
      cyc(1'b0, 20'h40000, 1'b1, 32'hFFFFFFFF, K_RD, 32'd0, "unmapped_wr");
      cyc(1'b0, 20'h40000, 1'b0, 32'd0, K_RD, 32'd0, "unmapped_rd2");

      switches = 16'h00A5;
      cyc(1'b0, 20'h70000, 1'b0, 32'd0, K_RD, 32'd0, "sw_sync1");
      cyc(1'b0, 20'h70000, 1'b0, 32'd0, K_RD, 32'd0, "sw_sync2");
      cyc(1'b0, 20'h70000, 1'b0, 32'd0, K_RD, 32'h000000A5, "sw_sync3");

      cyc(1'b0, 20'h71001, 1'b1, 32'd3, K_NONE, 32'd0, "load3");
      // k counts edges from the ctrl commit (k=0)
      for (int k = 0; k <= 86; k++) begin
         r = 1'b0; a = 20'h40000; w = 1'b0; d = 32'd0; kd = K_NONE; ex = 32'd0;
         if (k >= 1 && k <= 14) begin
            a = 20'h71002; kd = K_RD; ex = 32'(3 - (k - 1) / 4);
         end
         case (k)
            0:  begin a = 20'h71000; w = 1'b1; d = 32'd3; kd = K_RD; ex = 32'd0; end
            15: begin kd = K_IRQ; ex = 32'd0; end
            16: begin kd = K_IRQ; ex = 32'd1; end
            17: begin a = 20'h71002; kd = K_RD; ex = 32'd3; end
            18: begin a = 20'h71003; kd = K_RD; ex = 32'd1; end
            33: begin a = 20'h71003; kd = K_RD; ex = 32'd3; end
            34: begin a = 20'h71003; w = 1'b1; kd = K_RD; ex = 32'd3; end
            35: begin a = 20'h71003; kd = K_RD; ex = 32'd0; end
            36: begin kd = K_IRQ; ex = 32'd0; end
            48: begin a = 20'h71003; w = 1'b1; end
            49: begin a = 20'h71003; kd = K_RD; ex = 32'd1; end
            50: begin kd = K_IRQ; ex = 32'd1; end
            51: begin a = 20'h71000; w = 1'b1; d = 32'd1; end
            68: begin a = 20'h71000; kd = K_RD; ex = 32'd0; end
            69: begin a = 20'h71002; kd = K_RD; ex = 32'd0; end
            72: begin kd = K_IRQ; ex = 32'd1; end
            73: begin a = 20'h71002; kd = K_RD; ex = 32'd0; end
            74: begin a = 20'h71001; w = 1'b1; d = 32'd5; end
            75: begin a = 20'h71000; w = 1'b1; d = 32'd1; end
            80: begin a = 20'h71002; kd = K_RD; ex = 32'd4; end
            81: begin r = 1'b1; a = 20'h71002; kd = K_RD; ex = 32'd0; end
            82: begin a = 20'h71002; kd = K_RD; ex = 32'd0; end
            83: begin a = 20'h71003; kd = K_RD; ex = 32'd0; end
            84: begin kd = K_IRQ; ex = 32'd0; end
            85: begin a = 20'h00010; kd = K_RD; ex = 32'hDEADBEEF; end
            86: begin a = 20'h71000; kd = K_RD; ex = 32'd0; end
            default: ;
         endcase
         cyc(r, a, w, d, kd, ex, $sformatf("timer_k%0d", k));
      end

      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
